bram_loader: RTL and testbench
==============================

// Module: bram_loader
// PURPOSE
//  Write-side driver for the instruction/data BRAM: accepts a byte stream from the host link
//  (valid/ready), packs bytes little-endian into WRITE_WIDTH words and issues sequential BRAM
//  writes (w_addr/w_valid/w_data) from a programmed base address for a programmed word count.
//  Sits between the host deserializer and the BRAM write port; engines read the same BRAM.
// PARAMETERS
//  WRITE_WIDTH       32  BRAM write-port data width; multiple of 8
//  WRITE_ADDR_WIDTH  10  BRAM write-port address width (word addressed)
// PORTS
//  clk         in   1                   single clock, all logic posedge
//  rst         in   1                   reset, asynchronous, active-high
//  start       in   1                   1-cycle pulse: latch base_addr/word_count, begin load
//  base_addr   in   WRITE_ADDR_WIDTH    first word address
//  word_count  in   WRITE_ADDR_WIDTH+1  words to write (0..2**WRITE_ADDR_WIDTH)
//  abort       in   1                   cancel load, discard partial word
//  in_valid    in   1                   byte available
//  in_data     in   8                   byte
//  in_ready    out  1                   loader accepts byte this cycle
//  w_addr      out  WRITE_ADDR_WIDTH    to BRAM w_addr
//  w_valid     out  1                   to BRAM w_valid
//  w_data      out  WRITE_WIDTH         to BRAM w_data
//  busy        out  1                   state != IDLE
//  done        out  1                   1-cycle pulse after final write
//  overflow    out  1                   sticky: address wrapped past top; cleared on accepted start
// BEHAVIOUR
//  - Reset (async, active-high): state=IDLE; in_ready, w_valid, busy, done, overflow=0;
//    w_addr=0, w_data=0; byte index, remaining count, assembly register=0.
//  - BPW = WRITE_WIDTH/8 bytes per word. Byte accepted iff in_valid && in_ready.
//  - FSM IDLE/PACK/WRITE/DONE:
//    IDLE: in_ready=0. start -> latch addr/count, overflow<=0; count==0 -> DONE, else PACK, idx=0.
//    PACK: in_ready=1. Accepted byte k goes to w_data[8k+7:8k] (first byte = LSB). On byte
//          BPW-1 accepted -> WRITE next cycle.
//    WRITE: in_ready=0, w_valid=1 for exactly 1 cycle with current addr/word. Then addr+1
//          modulo 2**WRITE_ADDR_WIDTH (wrap 2**W-1 -> 0 sets overflow), remaining-1;
//          remaining==0 -> DONE else PACK.
//    DONE: done=1 one cycle -> IDLE.
//  - Latency: start@t -> in_ready@t+1; last byte of word@t -> w_valid@t+1; last w_valid@t
//    -> done@t+1. Throughput BPW+1 cycles/word with no input gaps.
//  - w_valid/in_ready/busy/done decoded from registered state only (no comb path in->out).
//  - start while busy: ignored. abort in any non-IDLE state: -> IDLE next cycle, no further
//    write, partial word dropped, done not pulsed; overflow retained. abort and start same
//    cycle in IDLE: abort wins, stays IDLE. abort in IDLE: no effect.
//  - in_valid gaps in PACK stall packing; bytes offered outside PACK are not consumed.
//  - w_data/w_addr hold last values outside WRITE.
// STRUCTURE
//  - bram_loader_pkg: typedef enum logic [1:0] {IDLE,PACK,WRITE,DONE} loader_state_t;
//    localparam BYTE_W = 8.
//  - Sub-module bram_word_packer: byte shift-in/index counter, emits word + word_full;
//    the FSM and address/count logic stay in bram_loader.
// TESTING (WRITE_WIDTH=32, WRITE_ADDR_WIDTH=10)
//  1. start base=0x010 count=2, bytes 11..88 back-to-back -> w@0x010=0x44332211,
//     w@0x011=0x88776655, done 1 cycle later, overflow=0, busy low after done.
//  2. start count=0 -> no w_valid, done at cycle after start, in_ready never high.
//  3. base=0x3FF count=2 -> w@0x3FF then w@0x000, overflow=1; next start clears it.
//  4. count=2, abort after 6 bytes -> single write @0x010, no second write, no done,
//     busy=0 next cycle; following start base=0x020 count=1 writes cleanly @0x020.
//  5. Random in_valid gaps + start pulses while busy -> identical writes to test 1,
//     in_ready=0 in WRITE, extra starts ignored.
//  6. rst asserted mid-PACK (not clock-aligned) -> all outputs 0 immediately; after release
//     start base=0x001 count=1 bytes AA BB CC DD -> w@0x001=0xDDCCBBAA.

Source files
------------

// File: rtl/bram_loader_pkg.sv
// Shared types and constants for the BRAM write-side loader.
package bram_loader_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PACK  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } loader_state_t;

endpackage

// File: rtl/bram_loader_if.sv
// Byte stream from the host link plus the BRAM write port driven by the loader.
interface bram_loader_if
    import bram_loader_pkg::*;
#(
    parameter int WRITE_WIDTH      = 32,
    parameter int WRITE_ADDR_WIDTH = 10
);

    logic                        in_valid;
    logic [BYTE_W-1:0]           in_data;
    logic                        in_ready;
    logic [WRITE_ADDR_WIDTH-1:0] w_addr;
    logic                        w_valid;
    logic [WRITE_WIDTH-1:0]      w_data;

    // Loader side: consumes bytes, drives the BRAM write port.
    modport master (
        input  in_valid, in_data,
        output in_ready, w_addr, w_valid, w_data
    );

    // Host/BRAM side: offers bytes, observes writes.
    modport slave (
        output in_valid, in_data,
        input  in_ready, w_addr, w_valid, w_data
    );

endinterface

// File: rtl/bram_word_packer.sv
// Little-endian byte-to-word assembler; word carries the byte accepted this cycle.
module bram_word_packer
    import bram_loader_pkg::*;
#(
    parameter int WRITE_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   accept,
    input  logic [BYTE_W-1:0]      byte_in,
    output logic [WRITE_WIDTH-1:0] word,
    output logic                   word_full
);

    localparam int BPW   = WRITE_WIDTH / BYTE_W;
    localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BPW - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    logic [IDX_W-1:0]       idx;
    logic [WRITE_WIDTH-1:0] assembly;

    // Merge the incoming byte combinationally so the full word is ready on the last byte.
    always_comb begin
        word = assembly;
        for (int k = 0; k < BPW; k++) begin
            if (accept && (idx == IDX_W'(k))) begin
                word[k*BYTE_W +: BYTE_W] = byte_in;
            end
        end
    end

    assign word_full = accept && (idx == LAST_IDX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx      <= '0;
            assembly <= '0;
        end else if (clear) begin
            idx      <= '0;
            assembly <= '0;
        end else if (accept) begin
            assembly <= word;
            idx      <= word_full ? '0 : idx + IDX_ONE;
        end
    end

endmodule

// File: rtl/bram_loader.sv
// Loads a host byte stream into BRAM as sequential WRITE_WIDTH words from a base address.
module bram_loader
    import bram_loader_pkg::*;
#(
    parameter int WRITE_WIDTH      = 32,
    parameter int WRITE_ADDR_WIDTH = 10
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [WRITE_ADDR_WIDTH-1:0] base_addr,
    input  logic [WRITE_ADDR_WIDTH:0]   word_count,
    input  logic                        abort,
    bram_loader_if.master               bus,
    output logic                        busy,
    output logic                        done,
    output logic                        overflow
);

    localparam logic [WRITE_ADDR_WIDTH-1:0] ADDR_ONE = WRITE_ADDR_WIDTH'(1);
    localparam logic [WRITE_ADDR_WIDTH:0]   CNT_ONE  = (WRITE_ADDR_WIDTH + 1)'(1);

    loader_state_t               state;
    logic [WRITE_ADDR_WIDTH-1:0] addr;
    logic [WRITE_ADDR_WIDTH-1:0] w_addr_r;
    logic [WRITE_ADDR_WIDTH:0]   remaining;
    logic [WRITE_WIDTH-1:0]      w_data_r;
    logic [WRITE_WIDTH-1:0]      packed_word;
    logic                        accept;
    logic                        word_full;
    logic                        pack_clear;

    // Handshake and status come from registered state only.
    assign bus.in_ready = (state == PACK);
    assign bus.w_valid  = (state == WRITE);
    assign bus.w_addr   = w_addr_r;
    assign bus.w_data   = w_data_r;
    assign busy         = (state != IDLE);
    assign done         = (state == DONE);

    assign accept     = bus.in_valid && (state == PACK);
    assign pack_clear = abort || (state == IDLE);

    bram_word_packer #(
        .WRITE_WIDTH(WRITE_WIDTH)
    ) u_packer (
        .clk      (clk),
        .rst      (rst),
        .clear    (pack_clear),
        .accept   (accept),
        .byte_in  (bus.in_data),
        .word     (packed_word),
        .word_full(word_full)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            addr      <= '0;
            remaining <= '0;
            w_addr_r  <= '0;
            w_data_r  <= '0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        addr      <= base_addr;
                        remaining <= word_count;
                        overflow  <= 1'b0;
                        state     <= (word_count == '0) ? DONE : PACK;
                    end
                end
                PACK: begin
                    if (abort) begin
                        state <= IDLE;
                    end else if (word_full) begin
                        w_addr_r <= addr;
                        w_data_r <= packed_word;
                        state    <= WRITE;
                    end
                end
                WRITE: begin
                    if (abort) begin
                        state <= IDLE;
                    end else begin
                        addr      <= addr + ADDR_ONE;
                        remaining <= remaining - CNT_ONE;
                        if (addr == '1) begin
                            overflow <= 1'b1;
                        end
                        state <= (remaining == CNT_ONE) ? DONE : PACK;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bram_loader.sv
// Scoreboard bench for bram_loader: expected writes queued at stimulus, checked at w_valid.
module tb_bram_loader;

    localparam int WW = 32;
    localparam int AW = 10;

    typedef struct {
        logic [AW-1:0] addr;
        logic [WW-1:0] data;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   word_count;
    logic          abort;
    logic          busy;
    logic          done;
    logic          overflow;

    int  n_cmp = 0;
    int  n_err = 0;
    int  wr_cnt = 0;
    int  done_cnt = 0;
    bit  finished = 1'b0;
    wr_t exp_q[$];

    bram_loader_if #(.WRITE_WIDTH(WW), .WRITE_ADDR_WIDTH(AW)) bus ();

    bram_loader #(
        .WRITE_WIDTH     (WW),
        .WRITE_ADDR_WIDTH(AW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .word_count(word_count),
        .abort     (abort),
        .bus       (bus),
        .busy      (busy),
        .done      (done),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Scoreboard consumer: every BRAM write must match the head of the expected queue.
    always @(negedge clk) begin
        if (bus.w_valid) begin
            wr_t e;
            wr_cnt++;
            check("write_pending", 64'(exp_q.size() != 0), 64'd1);
            check("ready_in_write", 64'(bus.in_ready), 64'd0);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("w_addr", 64'(bus.w_addr), 64'(e.addr));
                check("w_data", 64'(bus.w_data), 64'(e.data));
            end
        end
        if (done) done_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [AW-1:0] b, input logic [AW:0] c);
        base_addr  = b;
        word_count = c;
        start      = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic push_word(input logic [AW-1:0] a, input logic [WW-1:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, input bit noise);
        int n;
        logic acc;
        for (int g = 0; g < gap; g++) begin
            bus.in_valid = 1'b0;
            if (noise) begin
                start      = 1'($urandom_range(0, 1));
                base_addr  = 10'h2AA;
                word_count = 11'd5;
            end
            tick();
        end
        start        = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        n   = 0;
        acc = 1'b0;
        while (!acc && n < 64) begin
            acc = bus.in_ready;
            tick();
            n++;
        end
        bus.in_valid = 1'b0;
        if (!acc) check("byte_accept_timeout", 64'(acc), 64'd1);
    endtask

    task automatic run_done_checks(input string tag);
        check({tag, "_wvalid"}, 64'(bus.w_valid), 64'd1);
        tick();
        check({tag, "_done"}, 64'(done), 64'd1);
        tick();
        check({tag, "_done_low"}, 64'(done), 64'd0);
        check({tag, "_busy_low"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int w0;
        int d0;
        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        base_addr = '0;
        word_count = '0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        tick();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_ready", 64'(bus.in_ready), 64'd0);
        check("rst_wvalid", 64'(bus.w_valid), 64'd0);
        check("rst_waddr", 64'(bus.w_addr), 64'd0);
        check("rst_wdata", 64'(bus.w_data), 64'd0);
        check("rst_ovf", 64'(overflow), 64'd0);
        tick();
        rst = 1'b0;
        tick();

        // 1: two words back-to-back
        push_word(10'h010, 32'h44332211);
        push_word(10'h011, 32'h88776655);
        w0 = wr_cnt;
        do_start(10'h010, 11'd2);
        check("t1_ready_lat", 64'(bus.in_ready), 64'd1);
        check("t1_busy", 64'(busy), 64'd1);
        for (int i = 0; i < 8; i++) send_byte(8'(8'h11 * (i + 1)), 0, 1'b0);
        run_done_checks("t1");
        check("t1_ovf", 64'(overflow), 64'd0);
        check("t1_writes", 64'(wr_cnt - w0), 64'd2);

        // 2: zero-length load
        w0 = wr_cnt;
        do_start(10'h100, 11'd0);
        check("t2_done", 64'(done), 64'd1);
        check("t2_ready", 64'(bus.in_ready), 64'd0);
        tick();
        check("t2_busy_low", 64'(busy), 64'd0);
        check("t2_writes", 64'(wr_cnt - w0), 64'd0);

        // 3: address wrap sets overflow, next start clears it
        push_word(10'h3FF, 32'h04030201);
        push_word(10'h000, 32'h08070605);
        do_start(10'h3FF, 11'd2);
        for (int i = 0; i < 8; i++) send_byte(8'(i + 1), 0, 1'b0);
        run_done_checks("t3");
        check("t3_ovf_set", 64'(overflow), 64'd1);
        do_start(10'h050, 11'd0);
        check("t3_ovf_clr", 64'(overflow), 64'd0);
        tick();

        // abort and start together in IDLE: abort wins
        start = 1'b1;
        abort = 1'b1;
        base_addr = 10'h123;
        word_count = 11'd1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("idle_abort_busy", 64'(busy), 64'd0);

        // 4: abort mid-second-word
        push_word(10'h010, 32'hA4A3A2A1);
        w0 = wr_cnt;
        d0 = done_cnt;
        do_start(10'h010, 11'd2);
        for (int i = 0; i < 6; i++) send_byte(8'(8'hA1 + i), 0, 1'b0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t4_busy_low", 64'(busy), 64'd0);
        check("t4_ready_low", 64'(bus.in_ready), 64'd0);
        repeat (3) tick();
        check("t4_writes", 64'(wr_cnt - w0), 64'd1);
        check("t4_no_done", 64'(done_cnt - d0), 64'd0);
        push_word(10'h020, 32'h5A5B5C5D);
        do_start(10'h020, 11'd1);
        send_byte(8'h5D, 0, 1'b0);
        send_byte(8'h5C, 0, 1'b0);
        send_byte(8'h5B, 0, 1'b0);
        send_byte(8'h5A, 0, 1'b0);
        run_done_checks("t4b");

        // 5: random gaps and stray start pulses while busy
        push_word(10'h010, 32'h44332211);
        push_word(10'h011, 32'h88776655);
        w0 = wr_cnt;
        do_start(10'h010, 11'd2);
        for (int i = 0; i < 8; i++) send_byte(8'(8'h11 * (i + 1)), $urandom_range(0, 3), 1'b1);
        run_done_checks("t5");
        check("t5_writes", 64'(wr_cnt - w0), 64'd2);

        // 6: asynchronous reset in the middle of packing
        do_start(10'h030, 11'd2);
        send_byte(8'hE1, 0, 1'b0);
        send_byte(8'hE2, 0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("t6_busy", 64'(busy), 64'd0);
        check("t6_ready", 64'(bus.in_ready), 64'd0);
        check("t6_waddr", 64'(bus.w_addr), 64'd0);
        check("t6_wdata", 64'(bus.w_data), 64'd0);
        tick();
        tick();
        rst = 1'b0;
        push_word(10'h001, 32'hDDCCBBAA);
        do_start(10'h001, 11'd1);
        send_byte(8'hAA, 0, 1'b0);
        send_byte(8'hBB, 0, 1'b0);
        send_byte(8'hCC, 0, 1'b0);
        send_byte(8'hDD, 0, 1'b0);
        run_done_checks("t6");

        tick();
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        finished = 1'b1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        check("watchdog_finished", 64'(finished), 64'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
